// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: default operand width and
// the Montgomery multiplier control states.
package rsa_pkg;

    localparam int RSA_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REDUCE
    } mm_state_e;

endpackage

// File: rtl/mont_mul_step.sv
// One radix-2 Montgomery iteration: add b if a_bit, add n if odd, halve.
// Kept combinational and separate so the RUN datapath can be retimed alone.
module mont_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH+1:0] s,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH+1:0] s_next
);

    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_odd;

    always_comb begin
        t_add  = s + (a_bit ? {2'b00, b} : '0);
        // S < 2N keeps t_odd below 4N, so WIDTH+2 bits never overflow
        t_odd  = t_add[0] ? t_add + {2'b00, n} : t_add;
        s_next = t_odd >> 1;
    end

endmodule

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// One iteration per cycle in RUN, then a single conditional subtract.
module mont_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    mm_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH+1:0] s_q, s_d;
    logic [CW-1:0]    i_q, i_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH+1:0] s_next;
    logic [WIDTH+1:0] diff;
    logic [WIDTH+1:0] red;
    logic             unused_red_hi;

    mont_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .s      (s_q),
        .a_bit  (a_q[i_q]),
        .b      (b_q),
        .n      (n_q),
        .s_next (s_next)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        s_d      = s_q;
        i_d      = i_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        // borrow out of the subtract selects S itself when S < n
        diff     = s_q - {2'b00, n_q};
        red      = diff[WIDTH+1] ? s_q : diff;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n[0]) begin
                        a_d     = a;
                        b_d     = b;
                        n_d     = n;
                        s_d     = '0;
                        i_d     = '0;
                        state_d = RUN;
                    end else begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        result_d = '0;
                    end
                end
            end
            RUN: begin
                s_d = s_next;
                i_d = i_q + CW'(1);
                if (i_q == CW'(WIDTH - 1)) begin
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                result_d = red[WIDTH-1:0];
                done_d   = 1'b1;
                err_d    = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign unused_red_hi = ^red[WIDTH+1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            s_q      <= '0;
            i_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            s_q      <= s_d;
            i_q      <= i_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_mul.sv
// Scoreboard bench for mont_mul at WIDTH=8 and WIDTH=256 against an
// arithmetic reference (a*b mod n, then WIDTH modular halvings).
module tb_mont_mul;

    localparam int W8   = 8;
    localparam int W256 = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            start8, busy8, done8, err8;
    logic [W8-1:0]   a8, b8, n8, result8;
    logic            start256, busy256, done256, err256;
    logic [W256-1:0] a256, b256, n256, result256;

    mont_mul #(.WIDTH(W8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .n      (n8),
        .busy   (busy8),
        .done   (done8),
        .err    (err8),
        .result (result8)
    );

    mont_mul #(.WIDTH(W256)) dut256 (
        .clk    (clk),
        .rst    (rst),
        .start  (start256),
        .a      (a256),
        .b      (b256),
        .n      (n256),
        .busy   (busy256),
        .done   (done256),
        .err    (err256),
        .result (result256)
    );

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] res;
        logic         err;
        longint       cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q256[$];
    exp_t m8, m256;

    function automatic logic [255:0] ref_mont(logic [255:0] a, logic [255:0] b,
                                              logic [255:0] n, int w);
        logic [511:0] p;
        logic [511:0] nn;
        nn = {256'd0, n};
        p  = ({256'd0, a} * {256'd0, b}) % nn;
        // multiply by 2^-1 mod n, w times
        for (int k = 0; k < w; k++) p = p[0] ? (p + nn) >> 1 : p >> 1;
        return p[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    task automatic check(string name, logic [255:0] act, logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done8) begin
            check("busy8_with_done8", {255'd0, busy8}, 256'd0);
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done, expected none");
            end else begin
                m8 = q8.pop_front();
                check("result8", {248'd0, result8}, m8.res);
                check("err8", {255'd0, err8}, {255'd0, m8.err});
                check("latency8", 256'(cyc), 256'(m8.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done256) begin
            check("busy256_with_done256", {255'd0, busy256}, 256'd0);
            if (q256.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done256: got done, expected none");
            end else begin
                m256 = q256.pop_front();
                check("result256", result256, m256.res);
                check("err256", {255'd0, err256}, {255'd0, m256.err});
                check("latency256", 256'(cyc), 256'(m256.cyc));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge once idle.
    task automatic op8e(logic [7:0] a, logic [7:0] b, logic [7:0] n, logic [7:0] r);
        exp_t e;
        a8     = a;
        b8     = b;
        n8     = n;
        start8 = 1'b1;
        e.res  = {248'd0, r};
        e.err  = ~n[0];
        e.cyc  = n[0] ? cyc + W8 + 2 : cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        for (int g = 0; busy8 && g < 1000; g++) @(negedge clk);
        check("op8_timeout", {255'd0, busy8}, 256'd0);
    endtask

    task automatic op8(logic [7:0] a, logic [7:0] b, logic [7:0] n);
        logic [255:0] r;
        r = n[0] ? ref_mont({248'd0, a}, {248'd0, b}, {248'd0, n}, W8) : '0;
        op8e(a, b, n, r[7:0]);
    endtask

    task automatic op256(logic [255:0] a, logic [255:0] b, logic [255:0] n);
        exp_t e;
        a256     = a;
        b256     = b;
        n256     = n;
        start256 = 1'b1;
        e.res    = n[0] ? ref_mont(a, b, n, W256) : '0;
        e.err    = ~n[0];
        e.cyc    = n[0] ? cyc + W256 + 2 : cyc + 1;
        q256.push_back(e);
        @(negedge clk);
        start256 = 1'b0;
        for (int g = 0; busy256 && g < 1000; g++) @(negedge clk);
        check("op256_timeout", {255'd0, busy256}, 256'd0);
    endtask

    initial begin
        logic [7:0]   n_r8, a_r8, b_r8;
        logic [255:0] n_r, a_r, b_r;
        exp_t         e;

        rst      = 1'b1;
        start8   = 1'b0;
        a8       = '0;
        b8       = '0;
        n8       = '0;
        start256 = 1'b0;
        a256     = '0;
        b256     = '0;
        n256     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy8", {255'd0, busy8}, 256'd0);
        check("rst_done8", {255'd0, done8}, 256'd0);
        check("rst_err8", {255'd0, err8}, 256'd0);
        check("rst_result8", {248'd0, result8}, 256'd0);
        check("rst_busy256", {255'd0, busy256}, 256'd0);
        check("rst_done256", {255'd0, done256}, 256'd0);
        check("rst_result256", result256, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed cases; each start lands in the previous done cycle
        op8e(8'd5, 8'd7, 8'd13, 8'd1);
        op8e(8'd1, 8'd1, 8'd13, 8'd3);
        op8e(8'd12, 8'd12, 8'd13, 8'd3);
        op8e(8'd0, 8'd9, 8'd13, 8'd0);
        op8e(8'd254, 8'd254, 8'd255, 8'd1);
        op8e(8'd3, 8'd4, 8'd12, 8'd0);
        check("even_n_busy8", {255'd0, busy8}, 256'd0);
        op8e(8'd5, 8'd7, 8'd13, 8'd1);

        // start pulses while busy must be ignored
        a8     = 8'd12;
        b8     = 8'd12;
        n8     = 8'd13;
        start8 = 1'b1;
        e.res  = 256'd3;
        e.err  = 1'b0;
        e.cyc  = cyc + W8 + 2;
        q8.push_back(e);
        @(negedge clk);
        for (int g = 0; busy8 && g < 100; g++) begin
            start8 = 1'($urandom_range(0, 1));
            a8     = 8'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_starts_drained", 256'(q8.size()), 256'd0);

        // abort mid-RUN with reset
        a8     = 8'd5;
        b8     = 8'd7;
        n8     = 8'd13;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy8", {255'd0, busy8}, 256'd0);
        check("abort_done8", {255'd0, done8}, 256'd0);
        check("abort_err8", {255'd0, err8}, 256'd0);
        check("abort_result8", {248'd0, result8}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op8e(8'd5, 8'd7, 8'd13, 8'd1);

        for (int t = 0; t < 30; t++) begin
            n_r8 = 8'($urandom) | 8'd1;
            if (t % 7 == 3) n_r8[0] = 1'b0;
            if (n_r8 < 8'd3) n_r8 = 8'd3;
            a_r8 = 8'($urandom) % n_r8;
            b_r8 = 8'($urandom) % n_r8;
            op8(a_r8, b_r8, n_r8);
        end

        for (int t = 0; t < 250; t++) begin
            n_r    = rand256() >> $urandom_range(0, 200);
            n_r[0] = 1'b1;
            a_r    = rand256() % n_r;
            b_r    = rand256() % n_r;
            op256(a_r, b_r, n_r);
        end

        for (int g = 0; (q8.size() != 0 || q256.size() != 0) && g < 2000; g++)
            @(negedge clk);
        check("queues_drained", 256'(q8.size() + q256.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
